// File: rtl/aurora_pkg.sv
// -----------------------------------------------------------------------------
// aurora_pkg
//
// Purpose:
//   Shared definitions for the Aurora TX arbiter: the arbiter FSM state
//   encoding and the default TX data / byte-enable widths.
//
// Contents:
//   C_DATA_WIDTH  default TX data width in bits (32)
//   C_KEEP_WIDTH  default byte-enable width (C_DATA_WIDTH/8 = 4)
//   state_t       arbiter FSM state encoding
// -----------------------------------------------------------------------------
package aurora_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_KEEP_WIDTH = C_DATA_WIDTH / 8;

    // ST_FLUSH keeps the owner of the interrupted frame in a separate
    // register, so a single FLUSH state covers both requesters.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

endpackage : aurora_pkg

// File: rtl/aurora_tx_arbiter.sv
// -----------------------------------------------------------------------------
// aurora_tx_arbiter
//
// Purpose:
//   Frame-level two-way arbiter in front of an Aurora TX AXI-Stream port.
//   A requester is granted for a complete frame (no preemption). Ties in
//   IDLE are broken round-robin. The datapath is a zero-latency mux from
//   the owner to the Aurora core. When the channel goes down mid-frame
//   the rest of the frame is drained and discarded, and o_frame_abort
//   pulses once that frame has been consumed.
//
// Parameters:
//   P_DATA_WIDTH   TX data width in bits, big-endian [0:P_DATA_WIDTH-1]
//   P_KEEP_WIDTH   byte-enable width, P_DATA_WIDTH/8
//
// Ports:
//   i_user_clk          in   Aurora user clock, all logic on rising edge
//   i_rst_n             in   asynchronous active-low reset
//   i_channel_up        in   Aurora channel_up (i_user_clk domain)
//   s0_axi_tx_*         in   requester 0 AXI-Stream frame input
//   s0_axi_tx_tready    out  requester 0 ready
//   s1_axi_tx_*         in   requester 1 AXI-Stream frame input
//   s1_axi_tx_tready    out  requester 1 ready
//   m_axi_tx_*          out  AXI-Stream towards the Aurora core TX
//   m_axi_tx_tready     in   Aurora core TX ready
//   o_grant             out  one-hot current owner (bit0 s0, bit1 s1), 0 idle
//   o_frame_abort       out  one-cycle pulse when a flushed frame completes
//   o_frame_cnt0/1      out  frames fully delivered per requester (wraps)
// -----------------------------------------------------------------------------
module aurora_tx_arbiter
    import aurora_pkg::*;
#(
    parameter int P_DATA_WIDTH = C_DATA_WIDTH,
    parameter int P_KEEP_WIDTH = C_KEEP_WIDTH
) (
    input  logic                    i_user_clk,
    input  logic                    i_rst_n,
    input  logic                    i_channel_up,

    input  logic [0:P_DATA_WIDTH-1] s0_axi_tx_tdata,
    input  logic [0:P_KEEP_WIDTH-1] s0_axi_tx_tkeep,
    input  logic                    s0_axi_tx_tlast,
    input  logic                    s0_axi_tx_tvalid,
    output logic                    s0_axi_tx_tready,

    input  logic [0:P_DATA_WIDTH-1] s1_axi_tx_tdata,
    input  logic [0:P_KEEP_WIDTH-1] s1_axi_tx_tkeep,
    input  logic                    s1_axi_tx_tlast,
    input  logic                    s1_axi_tx_tvalid,
    output logic                    s1_axi_tx_tready,

    output logic [0:P_DATA_WIDTH-1] m_axi_tx_tdata,
    output logic [0:P_KEEP_WIDTH-1] m_axi_tx_tkeep,
    output logic                    m_axi_tx_tlast,
    output logic                    m_axi_tx_tvalid,
    input  logic                    m_axi_tx_tready,

    output logic [1:0]              o_grant,
    output logic                    o_frame_abort,
    output logic [15:0]             o_frame_cnt0,
    output logic [15:0]             o_frame_cnt1
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic        r_owner;        // 0 = s0, 1 = s1; meaningful in GRANT/FLUSH
    logic        r_rr_last;      // requester served last; reset 1 so s0 wins first
    logic [1:0]  r_grant;
    logic        r_frame_abort;
    logic [15:0] r_frame_cnt0;
    logic [15:0] r_frame_cnt1;

    logic        w_hs0;          // s0 beat accepted this cycle
    logic        w_hs1;          // s1 beat accepted this cycle
    logic        w_owner_hs;     // owner beat accepted this cycle
    logic        w_owner_last;   // owner's current beat is end of frame
    logic        w_req_any;      // at least one requester pending
    logic        w_pick1;        // IDLE arbitration picks s1

    // -------------------------------------------------------------------------
    // Datapath mux and ready steering
    //
    // In GRANTn the owner is wired straight through. tready keeps mirroring
    // the core even in the cycle the channel drops; the valid towards the
    // core is masked in that same cycle, so a beat accepted then is either
    // the final beat of the frame (counted as delivered) or the first
    // beat of the flush.
    // -------------------------------------------------------------------------
    always_comb begin
        s0_axi_tx_tready = 1'b0;
        s1_axi_tx_tready = 1'b0;
        m_axi_tx_tdata   = '0;
        m_axi_tx_tkeep   = '0;
        m_axi_tx_tlast   = 1'b0;
        m_axi_tx_tvalid  = 1'b0;

        unique case (r_state)
            ST_GRANT0: begin
                m_axi_tx_tdata   = s0_axi_tx_tdata;
                m_axi_tx_tkeep   = s0_axi_tx_tkeep;
                m_axi_tx_tlast   = s0_axi_tx_tlast;
                m_axi_tx_tvalid  = s0_axi_tx_tvalid & i_channel_up;
                s0_axi_tx_tready = m_axi_tx_tready;
            end
            ST_GRANT1: begin
                m_axi_tx_tdata   = s1_axi_tx_tdata;
                m_axi_tx_tkeep   = s1_axi_tx_tkeep;
                m_axi_tx_tlast   = s1_axi_tx_tlast;
                m_axi_tx_tvalid  = s1_axi_tx_tvalid & i_channel_up;
                s1_axi_tx_tready = m_axi_tx_tready;
            end
            ST_FLUSH: begin
                // Drain the owner unconditionally; nothing reaches the core.
                s0_axi_tx_tready = ~r_owner;
                s1_axi_tx_tready = r_owner;
            end
            default: begin
                // IDLE: everything held off.
            end
        endcase
    end

    assign w_hs0        = s0_axi_tx_tvalid & s0_axi_tx_tready;
    assign w_hs1        = s1_axi_tx_tvalid & s1_axi_tx_tready;
    assign w_owner_hs   = r_owner ? w_hs1 : w_hs0;
    assign w_owner_last = r_owner ? s1_axi_tx_tlast : s0_axi_tx_tlast;

    // Round-robin between two requesters: s1 wins when it is the only one
    // asking, or when both ask and s0 was the last one served.
    assign w_req_any = s0_axi_tx_tvalid | s1_axi_tx_tvalid;
    assign w_pick1   = s1_axi_tx_tvalid & (~s0_axi_tx_tvalid | ~r_rr_last);

    // -------------------------------------------------------------------------
    // Arbiter FSM with registered grant, abort pulse and frame counters
    // -------------------------------------------------------------------------
    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_rr_last     <= 1'b1;
            r_grant       <= 2'b00;
            r_frame_abort <= 1'b0;
            r_frame_cnt0  <= 16'd0;
            r_frame_cnt1  <= 16'd0;
        end else begin
            r_frame_abort <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    // No new grant while the link is down; requesters wait.
                    if (i_channel_up && w_req_any) begin
                        if (w_pick1) begin
                            r_state <= ST_GRANT1;
                            r_owner <= 1'b1;
                            r_grant <= 2'b10;
                        end else begin
                            r_state <= ST_GRANT0;
                            r_owner <= 1'b0;
                            r_grant <= 2'b01;
                        end
                    end
                end

                ST_GRANT0: begin
                    // End of frame wins over a simultaneous channel drop.
                    if (w_hs0 && s0_axi_tx_tlast) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= 2'b00;
                        r_rr_last    <= 1'b0;
                        r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
                    end else if (!i_channel_up) begin
                        r_state <= ST_FLUSH;
                    end
                end

                ST_GRANT1: begin
                    if (w_hs1 && s1_axi_tx_tlast) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= 2'b00;
                        r_rr_last    <= 1'b1;
                        r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
                    end else if (!i_channel_up) begin
                        r_state <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    // Grant stays with the owner until its frame is consumed.
                    if (w_owner_hs && w_owner_last) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= 2'b00;
                        r_rr_last     <= r_owner;
                        r_frame_abort <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_frame_abort = r_frame_abort;
    assign o_frame_cnt0  = r_frame_cnt0;
    assign o_frame_cnt1  = r_frame_cnt1;

endmodule : aurora_tx_arbiter

// File: tb/tb_aurora_tx_arbiter.sv
module tb_aurora_tx_arbiter;

    localparam int DW = 32;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          chan_up = 1'b0;

    logic [0:DW-1] s0_tdata = '0;
    logic [0:KW-1] s0_tkeep = '0;
    logic          s0_tlast = 1'b0;
    logic          s0_tvalid = 1'b0;
    logic          s0_tready;
    logic [0:DW-1] s1_tdata = '0;
    logic [0:KW-1] s1_tkeep = '0;
    logic          s1_tlast = 1'b0;
    logic          s1_tvalid = 1'b0;
    logic          s1_tready;
    logic [0:DW-1] m_tdata;
    logic [0:KW-1] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [1:0]    grant;
    logic          frame_abort;
    logic [15:0]   cnt0;
    logic [15:0]   cnt1;

    always #5 clk = ~clk;

    aurora_tx_arbiter #(
        .P_DATA_WIDTH (DW),
        .P_KEEP_WIDTH (KW)
    ) dut (
        .i_user_clk       (clk),
        .i_rst_n          (rst_n),
        .i_channel_up     (chan_up),
        .s0_axi_tx_tdata  (s0_tdata),
        .s0_axi_tx_tkeep  (s0_tkeep),
        .s0_axi_tx_tlast  (s0_tlast),
        .s0_axi_tx_tvalid (s0_tvalid),
        .s0_axi_tx_tready (s0_tready),
        .s1_axi_tx_tdata  (s1_tdata),
        .s1_axi_tx_tkeep  (s1_tkeep),
        .s1_axi_tx_tlast  (s1_tlast),
        .s1_axi_tx_tvalid (s1_tvalid),
        .s1_axi_tx_tready (s1_tready),
        .m_axi_tx_tdata   (m_tdata),
        .m_axi_tx_tkeep   (m_tkeep),
        .m_axi_tx_tlast   (m_tlast),
        .m_axi_tx_tvalid  (m_tvalid),
        .m_axi_tx_tready  (m_tready),
        .o_grant          (grant),
        .o_frame_abort    (frame_abort),
        .o_frame_cnt0     (cnt0),
        .o_frame_cnt1     (cnt1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    beat_t s0_q[$];
    beat_t s1_q[$];
    exp_t  exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Source models, sink scoreboard and protocol monitors.
    int    cyc = 0;
    int    first_beat = -1;
    int    last_beat = -1;
    int    abort_cnt = 0;
    int    abort_wide = 0;
    int    idle_viol = 0;
    logic  prev_abort = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    logic  hs0, hs1;
    exp_t  mon_e;
    beat_t drv_b;

    always begin
        @(negedge clk);
        cyc++;
        hs0 = s0_tvalid && s0_tready;
        hs1 = s1_tvalid && s1_tready;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_beat", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("sb_beat", {grant, m_tdata, m_tkeep, m_tlast}, mon_e);
            end
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
        end
        if (frame_abort) begin
            abort_cnt++;
            if (prev_abort) abort_wide++;
        end
        prev_abort = frame_abort;
        if (prev_grant != 2'b00 && grant != 2'b00 && grant != prev_grant) idle_viol++;
        prev_grant = grant;

        @(posedge clk);
        #1;
        if (hs0 && s0_q.size() != 0) void'(s0_q.pop_front());
        if (hs1 && s1_q.size() != 0) void'(s1_q.pop_front());
        if (s0_q.size() != 0) begin
            drv_b = s0_q[0];
            s0_tvalid = 1'b1; s0_tdata = drv_b.data; s0_tkeep = drv_b.keep; s0_tlast = drv_b.last;
        end else begin
            s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
        end
        if (s1_q.size() != 0) begin
            drv_b = s1_q[0];
            s1_tvalid = 1'b1; s1_tdata = drv_b.data; s1_tkeep = drv_b.keep; s1_tlast = drv_b.last;
        end else begin
            s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_beat(input int req, input logic [31:0] d, input logic [3:0] k,
                             input logic l, input bit to_sb);
        beat_t b;
        exp_t  e;
        b.data = d; b.keep = k; b.last = l;
        if (req == 0) s0_q.push_back(b);
        else          s1_q.push_back(b);
        if (to_sb) begin
            e.grant = (req == 0) ? 2'b01 : 2'b10;
            e.data = d; e.keep = k; e.last = l;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int maxcyc, input string tag);
        int k = 0;
        while ((s0_q.size() != 0 || s1_q.size() != 0 || exp_q.size() != 0) && k < maxcyc) begin
            step(1);
            k++;
        end
        check_val({tag, "_drain"}, 64'(k < maxcyc), 64'd1);
        step(2);
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        int k = 0;
        while (grant != g && k < 20) begin
            step(1);
            k++;
        end
        check_val({tag, "_grant_seen"}, 64'(grant), 64'(g));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_val({tag, "_grant"}, 64'(grant), 64'd0);
        check_val({tag, "_abort"}, 64'(frame_abort), 64'd0);
        check_val({tag, "_cnt"}, {cnt0, cnt1}, 64'd0);
        check_val({tag, "_ready_valid"}, {s0_tready, s1_tready, m_tvalid}, 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int ab0;
        int pat[4];

        #2;
        // Reset state
        do_reset("rst0");

        // Single 3-beat s0 frame, pass-through
        chan_up = 1'b1;
        push_beat(0, 32'h11111111, 4'hF, 1'b0, 1'b1);
        push_beat(0, 32'h22222222, 4'h3, 1'b0, 1'b1);
        push_beat(0, 32'h33333333, 4'h8, 1'b1, 1'b1);
        wait_drain(50, "t27");
        check_val("t27_cnt0", 64'(cnt0), 64'd1);
        check_val("t27_cnt1", 64'(cnt1), 64'd0);
        check_val("t27_grant_idle", 64'(grant), 64'd0);

        // Round-robin between back-to-back 2-beat frames
        do_reset("rst1");
        chan_up = 1'b1;
        first_beat = -1;
        idle_viol = 0;
        push_beat(0, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b1);
        push_beat(0, 32'hA1A1A1A1, 4'hE, 1'b1, 1'b1);
        push_beat(1, 32'hB0B0B0B0, 4'hD, 1'b0, 1'b1);
        push_beat(1, 32'hB1B1B1B1, 4'hC, 1'b1, 1'b1);
        push_beat(0, 32'hC0C0C0C0, 4'hB, 1'b0, 1'b1);
        push_beat(0, 32'hC1C1C1C1, 4'hA, 1'b1, 1'b1);
        push_beat(1, 32'hD0D0D0D0, 4'h9, 1'b0, 1'b1);
        push_beat(1, 32'hD1D1D1D1, 4'h7, 1'b1, 1'b1);
        // Reorder the expectations into the arbitration order s0,s1,s0,s1.
        begin
            exp_t tmp[$];
            tmp = exp_q;
            exp_q.delete();
            exp_q.push_back(tmp[0]); exp_q.push_back(tmp[1]);
            exp_q.push_back(tmp[2]); exp_q.push_back(tmp[3]);
            exp_q.push_back(tmp[4]); exp_q.push_back(tmp[5]);
            exp_q.push_back(tmp[6]); exp_q.push_back(tmp[7]);
        end
        wait_drain(100, "t28");
        check_val("t28_span", 64'(last_beat - first_beat), 64'd10);
        check_val("t28_idle_gap", 64'(idle_viol), 64'd0);
        check_val("t28_cnts", {cnt0, cnt1}, {16'd2, 16'd2});

        // Backpressure mirrored onto s1 during a 4-beat frame
        do_reset("rst2");
        chan_up = 1'b1;
        for (int i = 0; i < 4; i++)
            push_beat(1, 32'h51000000 + 32'(i), 4'(i + 1), 1'(i == 3), 1'b1);
        wait_grant(2'b10, "t29");
        pat = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            m_tready = 1'(pat[i]);
            #1;
            check_val("t29_s1_mirror", 64'(s1_tready), 64'(pat[i]));
            check_val("t29_s0_held", 64'(s0_tready), 64'd0);
            step(1);
        end
        m_tready = 1'b1;
        wait_drain(50, "t29");
        check_val("t29_cnt1", 64'(cnt1), 64'd1);

        // Channel loss after beat 2 of a 5-beat s0 frame
        do_reset("rst3");
        chan_up = 1'b1;
        for (int i = 0; i < 5; i++)
            push_beat(0, 32'h30000000 + 32'(i), 4'hF, 1'(i == 4), 1'(i < 2));
        wait_grant(2'b01, "t30");
        step(2);
        ab0 = abort_cnt;
        chan_up = 1'b0;
        #1;
        check_val("t30_m_valid_off", 64'(m_tvalid), 64'd0);
        check_val("t30_s0_ready", 64'(s0_tready), 64'd1);
        wait_drain(50, "t30");
        check_val("t30_abort_pulses", 64'(abort_cnt - ab0), 64'd1);
        check_val("t30_abort_width", 64'(abort_wide), 64'd0);
        check_val("t30_cnt0", 64'(cnt0), 64'd0);
        check_val("t30_grant_idle", 64'(grant), 64'd0);

        // Channel down in IDLE: requester waits, then proceeds
        push_beat(1, 32'hCAFEF00D, 4'h5, 1'b1, 1'b1);
        step(4);
        check_val("t20_no_grant", 64'(grant), 64'd0);
        check_val("t20_s1_held", 64'(s1_tready), 64'd0);
        check_val("t20_m_valid", 64'(m_tvalid), 64'd0);
        chan_up = 1'b1;
        wait_drain(50, "t20");
        check_val("t20_cnt1", 64'(cnt1), 64'd1);

        // Counter wrap on s1, then reset mid-frame
        do_reset("rst4");
        chan_up = 1'b1;
        for (int i = 0; i < 65535; i++)
            push_beat(1, 32'(i), 4'(i), 1'b1, 1'b1);
        wait_drain(140000, "t31a");
        check_val("t31_cnt1_ffff", 64'(cnt1), 64'hFFFF);
        push_beat(1, 32'h0BADBEEF, 4'h6, 1'b1, 1'b1);
        wait_drain(50, "t31b");
        check_val("t31_cnt1_wrap", 64'(cnt1), 64'h0000);
        check_val("t31_cnt0", 64'(cnt0), 64'h0000);

        for (int i = 0; i < 4; i++)
            push_beat(0, 32'h70000000 + 32'(i), 4'hF, 1'(i == 3), 1'b0);
        wait_grant(2'b01, "t31c");
        push_beat(0, 32'h0, 4'h0, 1'b0, 1'b0);
        void'(s0_q.pop_back());
        begin
            exp_t e;
            e.grant = 2'b01; e.data = 32'h70000000; e.keep = 4'hF; e.last = 1'b0;
            exp_q.push_back(e);
        end
        step(1);
        ab0 = abort_cnt;
        rst_n = 1'b0;
        #1;
        check_val("t31_rst_grant", 64'(grant), 64'd0);
        check_val("t31_rst_ready_valid", {s0_tready, s1_tready, m_tvalid}, 64'd0);
        check_val("t31_rst_cnts", {cnt0, cnt1}, 64'd0);
        check_val("t31_rst_abort", 64'(frame_abort), 64'd0);
        s0_q.delete();
        step(2);
        rst_n = 1'b1;
        step(5);
        check_val("t31_no_abort", 64'(abort_cnt - ab0), 64'd0);
        check_val("t31_grant_after", 64'(grant), 64'd0);
        check_val("t31_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_aurora_tx_arbiter
